// File: rtl/beep_pkg.sv
// Shared types and constants for the beep tone generator.
package beep_pkg;

    // Tone period word width, matching the note ROM data width.
    localparam int unsigned PERIOD_W   = 11;
    // Shortest period that produces a tone; anything below is a rest.
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StRest
    } beep_state_e;

endpackage

// File: rtl/beep_tick_presc.sv
// Tick prescaler: one-cycle tick every PRESC_DIV sclk cycles while enabled.
// Also usable by the upstream address sequencer as a tempo base.
module beep_tick_presc #(
    parameter int unsigned PRESC_DIV = 50
) (
    input  logic sclk,
    input  logic nrst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = $clog2(PRESC_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(PRESC_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntMax);

    // Count up and wrap; held at zero whenever disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge sclk) begin
        if (nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beep_pwm_gen.sv
// Square-wave beep generator fed by the note ROM. A new period (and volume,
// when BEEP_VOLUME_EN is defined) is taken only at a period boundary so the
// output never produces runt pulses. Defining BEEP_VOLUME_EN adds the vol
// input that narrows the high phase to 50/25/12.5/6.25% duty.
module beep_pwm_gen #(
    parameter int unsigned PRESC_DIV = 50,
    parameter int unsigned PERIOD_W  = beep_pkg::PERIOD_W
) (
    input  logic                sclk,
    input  logic                nrst,
    input  logic                en,
`ifdef BEEP_VOLUME_EN
    input  logic [1:0]          vol,
`endif
    input  logic [PERIOD_W-1:0] data,
    output logic                beep,
    output logic                period_done,
    output logic                busy
);

    import beep_pkg::*;

    beep_state_e         state_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] per_cnt_q;
    logic [PERIOD_W-1:0] high_len;
    logic                beep_q, done_q, busy_q;
    logic                tick, presc_en, beep_next, data_ok;
`ifdef BEEP_VOLUME_EN
    logic [1:0]          vol_q;
`endif

    // Prescaler only runs while actively playing or resting.
    assign presc_en = en && (state_q != StIdle);

    beep_tick_presc #(
        .PRESC_DIV(PRESC_DIV)
    ) u_presc (
        .sclk(sclk),
        .nrst(nrst),
        .en  (presc_en),
        .tick(tick)
    );

    // High-phase length and the combinational next beep level.
    always_comb begin
`ifdef BEEP_VOLUME_EN
        high_len = period_q >> (3'd1 + {1'b0, vol_q});
`else
        high_len = period_q >> 1;
`endif
        beep_next = per_cnt_q < high_len;
        data_ok   = data >= PERIOD_W'(MIN_PERIOD);
    end

    // Main FSM with registered outputs; en=0 overrides everything but reset.
    always_ff @(posedge sclk) begin
        if (nrst) begin
            state_q   <= StIdle;
            period_q  <= '0;
            per_cnt_q <= '0;
            beep_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef BEEP_VOLUME_EN
            vol_q     <= '0;
`endif
        end else if (!en) begin
            // Truncate any running period without a boundary pulse.
            state_q   <= StIdle;
            per_cnt_q <= '0;
            beep_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    period_q  <= data;
`ifdef BEEP_VOLUME_EN
                    vol_q     <= vol;
`endif
                    per_cnt_q <= '0;
                    beep_q    <= 1'b0;
                    busy_q    <= 1'b1;
                    state_q   <= data_ok ? StPlay : StRest;
                end
                StPlay: begin
                    beep_q <= beep_next;
                    if (tick) begin
                        if (per_cnt_q == period_q - PERIOD_W'(1)) begin
                            per_cnt_q <= '0;
                            done_q    <= 1'b1;
                            period_q  <= data;
`ifdef BEEP_VOLUME_EN
                            vol_q     <= vol;
`endif
                            if (!data_ok) begin
                                state_q <= StRest;
                            end
                        end else begin
                            per_cnt_q <= per_cnt_q + PERIOD_W'(1);
                        end
                    end
                end
                StRest: begin
                    beep_q    <= 1'b0;
                    per_cnt_q <= '0;
                    if (tick && data_ok) begin
                        period_q <= data;
`ifdef BEEP_VOLUME_EN
                        vol_q    <= vol;
`endif
                        state_q  <= StPlay;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign beep        = beep_q;
    assign period_done = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_beep_pwm_gen.sv
// Scoreboard bench for beep_pwm_gen with PRESC_DIV=4. Stimulus queues the
// expected beep edges and period_done pulses (with their sclk cycle); a
// separate monitor pops and compares each output event as it appears.
module tb_beep_pwm_gen;

    localparam int Div    = 4;
    localparam int EvRise = 0;
    localparam int EvFall = 1;
    localparam int EvDone = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic        sclk = 1'b0;
    logic        nrst;
    logic        en;
    logic [10:0] data;
    logic        beep;
    logic        period_done;
    logic        busy;
`ifdef BEEP_VOLUME_EN
    logic [1:0]  vol;
`endif

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic beep_prev = 1'b0;
    ev_t  exp_q[$];

    beep_pwm_gen #(
        .PRESC_DIV(Div),
        .PERIOD_W (11)
    ) dut (
        .sclk       (sclk),
        .nrst       (nrst),
        .en         (en),
`ifdef BEEP_VOLUME_EN
        .vol        (vol),
`endif
        .data       (data),
        .beep       (beep),
        .period_done(period_done),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    // Number of rising edges so far; stable when read on negedges.
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EvRise:  return "beep-rise";
            EvFall:  return "beep-fall";
            default: return "period_done";
        endcase
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        exp_q.push_back('{kind: kind, at: at});
    endtask

    // Period entered at edge s: beep rises one cycle later, stays high for
    // h ticks, and the boundary pulse shows up p ticks after s.
    task automatic push_period(input int s, input int p, input int h);
        if (h > 0) begin
            push_ev(EvRise, s + 1);
            push_ev(EvFall, s + 1 + Div * h);
        end
        push_ev(EvDone, s + Div * p);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge sclk);
    endtask

    task automatic seen(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at cycle %0d, required no event", ev_name(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                         ev_name(kind), cyc, ev_name(e.kind), e.at);
            end
        end
    endtask

    // Monitor: every beep edge and every period_done pulse is an event.
    initial begin
        forever begin
            @(negedge sclk);
            if (mon_en) begin
                if (beep !== beep_prev) seen(beep === 1'b1 ? EvRise : EvFall);
                if (period_done === 1'b1) seen(EvDone);
                beep_prev = beep;
            end
        end
    end

    // Stimulus.
    initial begin
        int s;
        int r;
        nrst = 1'b1;
        en   = 1'b0;
        data = 11'd0;
`ifdef BEEP_VOLUME_EN
        vol  = 2'd0;
`endif
        repeat (3) @(negedge sclk);
        check("reset beep", beep, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset period_done", period_done, 1'b0);
        beep_prev = beep;
        mon_en    = 1'b1;
        nrst      = 1'b0;

        // data=10: 20 high / 20 low; 10->6 mid-period only applies later.
        at_cyc(4);
        en   = 1'b1;
        data = 11'd10;
        s    = cyc + 1;
        push_period(s, 10, 5);
        push_period(s + 40, 10, 5);
        push_period(s + 80, 6, 3);
        push_period(s + 104, 6, 3);
        at_cyc(s + 1);
        check("busy in play", busy, 1'b1);
        at_cyc(s + 55);
        data = 11'd6;
        at_cyc(s + 114);
        data = 11'd0;

        // Boundary at r loads a rest; then data=8 starts play on next tick.
        r = s + 128;
        at_cyc(r + 3);
        check("busy in rest", busy, 1'b1);
        check("beep in rest", beep, 1'b0);
        at_cyc(r + 6);
        data = 11'd8;
        s    = r + 8;
        push_period(s, 8, 4);

        // en drops 3 cycles into the next high phase.
        push_ev(EvRise, s + 33);
        push_ev(EvFall, s + 36);
        at_cyc(s + 35);
        en = 1'b0;
        at_cyc(s + 36);
        check("busy after en drop", busy, 1'b0);
        check("beep after en drop", beep, 1'b0);
        check("no done after en drop", period_done, 1'b0);
        at_cyc(s + 40);
        en = 1'b1;
        s  = cyc + 1;
        push_period(s, 8, 4);

        // Load 2047 at the next boundary, then reset mid-high-phase.
        at_cyc(s + 5);
        data = 11'd2047;
        s    = s + 32;
        push_ev(EvRise, s + 1);
        push_ev(EvFall, s + 11);
        at_cyc(s + 2);
        check("beep high at 2047", beep, 1'b1);
        at_cyc(s + 10);
        nrst = 1'b1;
        at_cyc(s + 11);
        check("mid-play reset beep", beep, 1'b0);
        check("mid-play reset busy", busy, 1'b0);
        check("mid-play reset period_done", period_done, 1'b0);
        nrst = 1'b0;
        s    = s + 12;
        push_period(s, 2047, 1023);
        at_cyc(s + 8188);
        en = 1'b0;

`ifdef BEEP_VOLUME_EN
        // vol=2: 16 >> 3 = 2 ticks high; vol=0 takes effect at the boundary.
        at_cyc(s + 8192);
        vol  = 2'd2;
        data = 11'd16;
        en   = 1'b1;
        s    = cyc + 1;
        push_period(s, 16, 2);
        push_period(s + 64, 16, 8);
        at_cyc(s + 10);
        vol = 2'd0;
        at_cyc(s + 128);
        en = 1'b0;
`endif

        repeat (6) @(negedge sclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending events: got %0d still outstanding, required 0 (next %s at %0d)",
                     exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].at);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        repeat (30000) @(posedge sclk);
        checks++;
        errors++;
        $display("FAIL watchdog: got cycle %0d, required finish before it", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
